// File: rtl/iwrr_weight_tracker.sv
// Weight tracker and output register for an interleaved weighted round-robin
// arbiter. Holds one grant from the external priority granter until it is
// accepted, counts accepted grants per requester against its weight, and
// reports which requesters have used up their share of the current round.
module iwrr_weight_tracker #(
    parameter int P_REQUESTER_NUM = 3,
    parameter int P_WEIGHT_W      = 4
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic [P_REQUESTER_NUM-1:0]            request,
    input  logic [P_REQUESTER_NUM-1:0]            prior_grant,
    input  logic [P_REQUESTER_NUM*P_WEIGHT_W-1:0] weight,
    input  logic                                  grant_ready,
    output logic [P_REQUESTER_NUM-1:0]            request_weight_completed,
    output logic                                  grant_valid,
    output logic [P_REQUESTER_NUM-1:0]            grant,
    output logic                                  round_end
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t state;

    logic [P_REQUESTER_NUM-1:0][P_WEIGHT_W-1:0] cnt;
    logic [P_REQUESTER_NUM-1:0][P_WEIGHT_W-1:0] cnt_inc;
    logic [P_REQUESTER_NUM-1:0][P_WEIGHT_W-1:0] weff;
    logic [P_REQUESTER_NUM-1:0][P_WEIGHT_W:0]   cnt_sum;
    logic [P_REQUESTER_NUM-1:0]                 comp_nx;
    logic [P_REQUESTER_NUM-1:0]                 first_grant;
    logic                                       accept;
    logic                                       round_close;

    // Isolate the lowest-index set bit so the held grant is always one-hot
    always_comb begin
        first_grant = prior_grant & (~prior_grant + P_REQUESTER_NUM'(1));
    end

    // Per-requester increment, weight compare and next-state completed bits
    always_comb begin
        accept  = grant_valid & grant_ready;
        weff    = '0;
        cnt_sum = '0;
        cnt_inc = '0;
        comp_nx = request_weight_completed;
        for (int unsigned i = 0; i < P_REQUESTER_NUM; i++) begin
            weff[i]    = (weight[i*P_WEIGHT_W +: P_WEIGHT_W] == '0) ?
                         P_WEIGHT_W'(1) : weight[i*P_WEIGHT_W +: P_WEIGHT_W];
            // one extra bit so the compare sees cnt+1 even when cnt is all-ones
            cnt_sum[i] = {1'b0, cnt[i]} + (P_WEIGHT_W + 1)'(1);
            cnt_inc[i] = (&cnt[i]) ? cnt[i] : cnt_sum[i][P_WEIGHT_W-1:0];
            if (accept && grant[i] && (cnt_sum[i] >= {1'b0, weff[i]})) begin
                comp_nx[i] = 1'b1;
            end
        end
        round_close = (comp_nx != '0) && ((request & ~comp_nx) == '0);
    end

    // Output stage: load a grant when empty, hold it until accepted
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= EMPTY;
            grant_valid <= 1'b0;
            grant       <= '0;
        end else begin
            case (state)
                EMPTY: begin
                    if (prior_grant != '0) begin
                        state       <= FULL;
                        grant_valid <= 1'b1;
                        grant       <= first_grant;
                    end else begin
                        grant <= '0;
                    end
                end
                FULL: begin
                    // no reload here: the bubble lets the granter see the new completed bits
                    if (grant_ready) begin
                        state       <= EMPTY;
                        grant_valid <= 1'b0;
                        grant       <= '0;
                    end
                end
            endcase
        end
    end

    // Weight accounting and round close; a close wins over a same-cycle increment
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt                      <= '0;
            request_weight_completed <= '0;
            round_end                <= 1'b0;
        end else if (round_close) begin
            cnt                      <= '0;
            request_weight_completed <= '0;
            round_end                <= 1'b1;
        end else begin
            round_end                <= 1'b0;
            request_weight_completed <= comp_nx;
            for (int unsigned i = 0; i < P_REQUESTER_NUM; i++) begin
                if (accept && grant[i]) begin
                    cnt[i] <= cnt_inc[i];
                end
            end
        end
    end

endmodule

// File: tb/tb_iwrr_weight_tracker.sv
// Bench for iwrr_weight_tracker: directed scenarios plus a randomized run,
// all compared against a transaction-level model of the weighted round.
module tb_iwrr_weight_tracker;

    localparam int N = 3;
    localparam int W = 4;
    localparam int CMAX = (1 << W) - 1;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [N-1:0]   request = '0;
    logic [N-1:0]   prior_grant = '0;
    logic [N*W-1:0] weight = '0;
    logic           grant_ready = 1'b0;
    logic [N-1:0]   request_weight_completed;
    logic           grant_valid;
    logic [N-1:0]   grant;
    logic           round_end;

    int checks = 0;
    int errors = 0;

    // model state
    logic         m_valid = 1'b0;
    logic [N-1:0] m_grant = '0;
    logic [N-1:0] m_comp = '0;
    logic         m_re = 1'b0;
    int           m_cnt[N];

    bit           use_granter = 1'b1;
    logic [N-1:0] pg_force = '0;

    iwrr_weight_tracker #(
        .P_REQUESTER_NUM(N),
        .P_WEIGHT_W(W)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .request(request),
        .prior_grant(prior_grant),
        .weight(weight),
        .grant_ready(grant_ready),
        .request_weight_completed(request_weight_completed),
        .grant_valid(grant_valid),
        .grant(grant),
        .round_end(round_end)
    );

    always #5 clk = ~clk;

    function automatic logic [N-1:0] lowest(input logic [N-1:0] v);
        logic [N-1:0] r;
        r = '0;
        for (int i = 0; i < N; i++) begin
            if (v[i]) begin
                r[i] = 1'b1;
                return r;
            end
        end
        return r;
    endfunction

    function automatic int wv(input int i);
        logic [W-1:0] f;
        f = weight[i*W +: W];
        return int'(f);
    endfunction

    function automatic logic [2*N+1:0] obs();
        return {grant_valid, grant, request_weight_completed, round_end};
    endfunction

    function automatic logic [2*N+1:0] expv();
        return {m_valid, m_grant, m_comp, m_re};
    endfunction

    // Reference behaviour for one clock edge, from the round rules
    task automatic model_edge();
        int           nc[N];
        int           weff;
        logic [N-1:0] cn;
        bit           acc;
        if (!rst_n) begin
            m_valid = 1'b0;
            m_grant = '0;
            m_comp  = '0;
            m_re    = 1'b0;
            for (int i = 0; i < N; i++) m_cnt[i] = 0;
            return;
        end
        acc = m_valid && grant_ready;
        cn  = m_comp;
        for (int i = 0; i < N; i++) begin
            nc[i] = m_cnt[i];
            if (acc && m_grant[i]) begin
                weff = (wv(i) == 0) ? 1 : wv(i);
                if (m_cnt[i] + 1 >= weff) cn[i] = 1'b1;
                nc[i] = (m_cnt[i] + 1 > CMAX) ? CMAX : m_cnt[i] + 1;
            end
        end
        if (cn != '0 && (request & ~cn) == '0) begin
            for (int i = 0; i < N; i++) m_cnt[i] = 0;
            m_comp = '0;
            m_re   = 1'b1;
        end else begin
            for (int i = 0; i < N; i++) m_cnt[i] = nc[i];
            m_comp = cn;
            m_re   = 1'b0;
        end
        if (m_valid) begin
            if (grant_ready) begin
                m_valid = 1'b0;
                m_grant = '0;
            end
        end else if (prior_grant != '0) begin
            m_valid = 1'b1;
            m_grant = lowest(prior_grant);
        end else begin
            m_grant = '0;
        end
    endtask

    // Drive the granter, advance model and DUT by one edge, settle before sampling
    task automatic cycle();
        prior_grant = use_granter ? lowest(request & ~m_comp) : pg_force;
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        request = '1;
        use_granter = 1'b0;
        pg_force = '1;
        grant_ready = 1'b0;
        repeat (2) cycle();
        checks++;
        if (obs() !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got %b expected %b", obs(), {(2*N+2){1'b0}});
        end
        rst_n = 1'b1;
        use_granter = 1'b1;
    endtask

    task automatic test_weighted_round();
        logic [N-1:0] seen[$];
        logic [N-1:0] want[6];
        bit           closed;
        want = '{3'b001, 3'b001, 3'b010, 3'b100, 3'b100, 3'b100};
        do_reset();
        weight = {4'd3, 4'd1, 4'd2};
        request = 3'b111;
        grant_ready = 1'b1;
        use_granter = 1'b1;
        closed = 1'b0;
        for (int c = 0; c < 30 && !closed; c++) begin
            cycle();
            checks++;
            if (obs() !== expv()) begin
                errors++;
                $display("FAIL round_cycle: got %b expected %b", obs(), expv());
            end
            if (grant_valid === 1'b1) seen.push_back(grant);
            if (round_end === 1'b1) begin
                closed = 1'b1;
                checks++;
                if (request_weight_completed !== 3'b000) begin
                    errors++;
                    $display("FAIL round_clear: got %b expected 000", request_weight_completed);
                end
            end
        end
        checks++;
        if (!closed) begin
            errors++;
            $display("FAIL round_timeout: got no round_end expected pulse");
        end
        checks++;
        if (seen.size() != 6) begin
            errors++;
            $display("FAIL round_len: got %0d expected 6", seen.size());
        end else begin
            for (int k = 0; k < 6; k++) begin
                checks++;
                if (seen[k] !== want[k]) begin
                    errors++;
                    $display("FAIL round_seq[%0d]: got %b expected %b", k, seen[k], want[k]);
                end
            end
        end
    endtask

    task automatic test_ready_stall();
        do_reset();
        weight = {4'd1, 4'd2, 4'd1};
        request = 3'b010;
        grant_ready = 1'b0;
        use_granter = 1'b1;
        cycle();
        for (int c = 0; c < 5; c++) begin
            if (c == 2) request = 3'b000;
            cycle();
            checks++;
            if ({grant_valid, grant, request_weight_completed, round_end} !== {1'b1, 3'b010, 3'b000, 1'b0}) begin
                errors++;
                $display("FAIL stall_hold[%0d]: got %b expected 1_010_000_0", c, obs());
            end
        end
        request = 3'b010;
        grant_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            cycle();
            checks++;
            if (obs() !== expv()) begin
                errors++;
                $display("FAIL stall_after[%0d]: got %b expected %b", c, obs(), expv());
            end
            checks++;
            if (round_end !== (c == 2)) begin
                errors++;
                $display("FAIL stall_count[%0d]: got round_end %b expected %b", c, round_end, c == 2);
            end
        end
    endtask

    task automatic test_non_one_hot();
        do_reset();
        weight = {4'd1, 4'd2, 4'd1};
        request = 3'b110;
        use_granter = 1'b0;
        pg_force = 3'b110;
        grant_ready = 1'b0;
        cycle();
        checks++;
        if ({grant_valid, grant} !== 4'b1_010) begin
            errors++;
            $display("FAIL one_hot_load: got %b expected 1010", {grant_valid, grant});
        end
        pg_force = 3'b000;
        grant_ready = 1'b1;
        repeat (2) begin
            cycle();
            checks++;
            if (obs() !== expv()) begin
                errors++;
                $display("FAIL one_hot_after: got %b expected %b", obs(), expv());
            end
        end
        use_granter = 1'b1;
    endtask

    task automatic test_weight_zero();
        int pulses;
        do_reset();
        weight = '0;
        request = 3'b010;
        grant_ready = 1'b1;
        use_granter = 1'b1;
        pulses = 0;
        for (int c = 0; c < 12; c++) begin
            cycle();
            checks++;
            if (obs() !== expv()) begin
                errors++;
                $display("FAIL wzero_cycle: got %b expected %b", obs(), expv());
            end
            if (round_end === 1'b1) pulses++;
        end
        checks++;
        if (pulses != 6) begin
            errors++;
            $display("FAIL wzero_pulses: got %0d expected 6", pulses);
        end
    endtask

    task automatic test_reset_in_full();
        int at;
        do_reset();
        weight = {4'd1, 4'd1, 4'd3};
        request = 3'b001;
        grant_ready = 1'b1;
        use_granter = 1'b1;
        repeat (2) cycle();
        grant_ready = 1'b0;
        cycle();
        checks++;
        if ({grant_valid, grant} !== 4'b1_001) begin
            errors++;
            $display("FAIL rstfull_pre: got %b expected 1001", {grant_valid, grant});
        end
        rst_n = 1'b0;
        cycle();
        checks++;
        if (obs() !== '0) begin
            errors++;
            $display("FAIL rstfull_clear: got %b expected all zero", obs());
        end
        rst_n = 1'b1;
        grant_ready = 1'b1;
        at = -1;
        for (int c = 1; c <= 10 && at < 0; c++) begin
            cycle();
            checks++;
            if (obs() !== expv()) begin
                errors++;
                $display("FAIL rstfull_cycle: got %b expected %b", obs(), expv());
            end
            if (round_end === 1'b1) at = c;
        end
        checks++;
        if (at != 6) begin
            errors++;
            $display("FAIL rstfull_recount: got round_end at cycle %0d expected 6", at);
        end
    endtask

    task automatic test_drop_request();
        do_reset();
        weight = {4'd1, 4'd3, 4'd3};
        request = 3'b101;
        use_granter = 1'b0;
        pg_force = 3'b100;
        grant_ready = 1'b1;
        cycle();
        pg_force = 3'b000;
        cycle();
        checks++;
        if ({request_weight_completed, round_end} !== 4'b100_0) begin
            errors++;
            $display("FAIL drop_pre: got %b expected 1000", {request_weight_completed, round_end});
        end
        request = 3'b000;
        cycle();
        checks++;
        if ({request_weight_completed, round_end} !== 4'b000_1) begin
            errors++;
            $display("FAIL drop_close: got %b expected 0001", {request_weight_completed, round_end});
        end
        cycle();
        checks++;
        if (round_end !== 1'b0) begin
            errors++;
            $display("FAIL drop_pulse_len: got %b expected 0", round_end);
        end
        use_granter = 1'b1;
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 800; c++) begin
            if ($urandom_range(0, 3) == 0) request = N'($urandom);
            if ($urandom_range(0, 15) == 0) weight = (N*W)'($urandom);
            grant_ready = ($urandom_range(0, 3) != 0);
            use_granter = ($urandom_range(0, 4) != 0);
            pg_force = ($urandom_range(0, 1) == 0) ? (request & N'($urandom)) : N'($urandom);
            rst_n = ($urandom_range(0, 99) != 0);
            cycle();
            checks++;
            if (obs() !== expv()) begin
                errors++;
                $display("FAIL random[%0d]: got %b expected %b", c, obs(), expv());
            end
        end
        rst_n = 1'b1;
        use_granter = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < N; i++) m_cnt[i] = 0;
        @(negedge clk);
        test_reset();
        test_weighted_round();
        test_ready_stall();
        test_non_one_hot();
        test_weight_zero();
        test_reset_in_full();
        test_drop_request();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
